// File: rtl/mtr_drv_n.sv
// mtr_drv_n: multi-channel H-bridge PWM driver.
// A shared free-running counter sets the PWM period. Speed and direction are
// captured into shadow registers only at the period boundary, so a period is
// never glitched mid-way. A direction reversal holds both outputs of that
// channel low for DEAD_CYC clocks so the bridge is never shoot-through.
// Optional feature macro: MTR_DRV_BRAKE_EN adds a per-channel brake input
// that forces the channel outputs low without disturbing its internal state.
module mtr_drv_n #(
    parameter int NUM_CH   = 2,
    parameter int WIDTH    = 11,
    parameter int DEAD_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] spd,
    input  logic [NUM_CH-1:0]       rev,
`ifdef MTR_DRV_BRAKE_EN
    input  logic [NUM_CH-1:0]       brake,
`endif
    output logic [NUM_CH-1:0]       PWM_frwrd,
    output logic [NUM_CH-1:0]       PWM_rev,
    output logic                    period_start,
    output logic [NUM_CH-1:0]       dir_busy
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] DEAD_VAL = DEAD_CYC[WIDTH-1:0];

    logic [WIDTH-1:0]             cnt_q, cnt_d;
    logic [NUM_CH-1:0][WIDTH-1:0] spd_sh_q, spd_sh_d;
    logic [NUM_CH-1:0]            rev_sh_q, rev_sh_d;
    logic [NUM_CH-1:0][WIDTH-1:0] dead_q, dead_d;
    logic [NUM_CH-1:0]            pwm_f_q, pwm_f_d;
    logic [NUM_CH-1:0]            pwm_r_q, pwm_r_d;
    logic [NUM_CH-1:0]            ch_on;
    logic [NUM_CH-1:0]            brake_v;
    logic                         load;

`ifdef MTR_DRV_BRAKE_EN
    assign brake_v = brake;
`else
    assign brake_v = '0;
`endif

    // The last count of the period is the instant every channel picks up new settings.
    assign load = (cnt_q == CNT_MAX);

    // Next-state logic: counter, shadow capture, dead-time countdown and PWM compare.
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        spd_sh_d = spd_sh_q;
        rev_sh_d = rev_sh_q;
        dead_d   = dead_q;
        pwm_f_d  = '0;
        pwm_r_d  = '0;
        ch_on    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load) begin
                spd_sh_d[i] = spd[i*WIDTH +: WIDTH];
                rev_sh_d[i] = rev[i];
            end
            if (load && (rev[i] != rev_sh_q[i])) begin
                dead_d[i] = DEAD_VAL;
            end else if (dead_q[i] != '0) begin
                dead_d[i] = dead_q[i] - 1'b1;
            end
            ch_on[i]   = (cnt_q < spd_sh_q[i]) && (dead_q[i] == '0);
            pwm_f_d[i] = ch_on[i] & ~rev_sh_q[i] & ~brake_v[i];
            pwm_r_d[i] = ch_on[i] &  rev_sh_q[i] & ~brake_v[i];
        end
    end

    // State registers; reset clears everything so outputs drop immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            spd_sh_q <= '0;
            rev_sh_q <= '0;
            dead_q   <= '0;
            pwm_f_q  <= '0;
            pwm_r_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            spd_sh_q <= spd_sh_d;
            rev_sh_q <= rev_sh_d;
            dead_q   <= dead_d;
            pwm_f_q  <= pwm_f_d;
            pwm_r_q  <= pwm_r_d;
        end
    end

    // Status outputs derived directly from the registers.
    always_comb begin
        period_start = (cnt_q == '0);
        for (int i = 0; i < NUM_CH; i++) begin
            dir_busy[i] = (dead_q[i] != '0);
        end
    end

    assign PWM_frwrd = pwm_f_q;
    assign PWM_rev   = pwm_r_q;

endmodule

// File: tb/tb_mtr_drv_n.sv
// tb_mtr_drv_n: directed bench for mtr_drv_n (NUM_CH=2, WIDTH=11, DEAD_CYC=16).
// A period-level model predicts every output each clock; per-period high-time
// tallies are also pinned against hand-computed pulse widths.
// Optional feature macro: MTR_DRV_BRAKE_EN enables the brake scenario.
module tb_mtr_drv_n;

    localparam int NUM_CH = 2;
    localparam int WIDTH  = 11;
    localparam int DEAD   = 16;
    localparam int PERIOD = 2048;
    localparam int MAXC   = PERIOD - 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH*WIDTH-1:0] spd = '0;
    logic [NUM_CH-1:0]       rev = '0;
    logic [NUM_CH-1:0]       brake_in = '0;
    logic [NUM_CH-1:0]       PWM_frwrd;
    logic [NUM_CH-1:0]       PWM_rev;
    logic                    period_start;
    logic [NUM_CH-1:0]       dir_busy;

    int errors = 0;
    int checks = 0;

    mtr_drv_n #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEAD_CYC(DEAD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spd          (spd),
        .rev          (rev),
`ifdef MTR_DRV_BRAKE_EN
        .brake        (brake_in),
`endif
        .PWM_frwrd    (PWM_frwrd),
        .PWM_rev      (PWM_rev),
        .period_start (period_start),
        .dir_busy     (dir_busy)
    );

    always #5 clk = ~clk;

    // Model state: settings in force for the current period and position in it.
    int          m_cnt;
    int          m_p;
    int          m_spd [NUM_CH];
    bit          m_rev [NUM_CH];
    bit          m_chg [NUM_CH];
    bit          m_on;
    logic [NUM_CH-1:0] exp_f, exp_r, exp_busy;
    logic        exp_ps;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int s0, input int s1, input bit r0, input bit r1);
        spd[0*WIDTH +: WIDTH] = WIDTH'(s0);
        spd[1*WIDTH +: WIDTH] = WIDTH'(s1);
        rev[0] = r0;
        rev[1] = r1;
    endtask

    // Period-level model: output high while the period position is below the
    // latched speed, except the first DEAD positions of a period that began
    // with a direction change; settings are taken at the end of each period.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    = 0;
            exp_f    = '0;
            exp_r    = '0;
            exp_busy = '0;
            exp_ps   = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                m_spd[c] = 0;
                m_rev[c] = 1'b0;
                m_chg[c] = 1'b0;
            end
        end else begin
            m_p = m_cnt;
            for (int c = 0; c < NUM_CH; c++) begin
                m_on     = (m_p < m_spd[c]) && !(m_chg[c] && (m_p < DEAD));
                exp_f[c] = m_on && !m_rev[c] && !brake_in[c];
                exp_r[c] = m_on &&  m_rev[c] && !brake_in[c];
            end
            if (m_p == MAXC) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    m_chg[c] = (rev[c] != m_rev[c]);
                    m_rev[c] = rev[c];
                    m_spd[c] = int'(spd[c*WIDTH +: WIDTH]);
                end
            end
            m_cnt = (m_p + 1) % PERIOD;
            for (int c = 0; c < NUM_CH; c++) begin
                exp_busy[c] = m_chg[c] && (m_cnt < DEAD);
            end
            exp_ps = (m_cnt == 0);
        end
    end

    // Per-cycle comparison of every output against the model, plus the no-overlap rule.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("pwm_frwrd", 32'(PWM_frwrd), 32'(exp_f));
            checkOutput("pwm_rev", 32'(PWM_rev), 32'(exp_r));
            checkOutput("dir_busy", 32'(dir_busy), 32'(exp_busy));
            checkOutput("period_start", 32'(period_start), 32'(exp_ps));
            checkOutput("no_overlap", 32'(PWM_frwrd & PWM_rev), 32'd0);
        end
    end

    // Per-period tallies of high samples, published when the counter returns to 0.
    int acc_f [NUM_CH];
    int acc_r [NUM_CH];
    int acc_b [NUM_CH];
    int pub_f [NUM_CH];
    int pub_r [NUM_CH];
    int pub_b [NUM_CH];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_f[c] = 0;
                acc_r[c] = 0;
                acc_b[c] = 0;
            end
        end else if (m_cnt == 0) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pub_f[c] = acc_f[c] + int'(PWM_frwrd[c]);
                pub_r[c] = acc_r[c] + int'(PWM_rev[c]);
                pub_b[c] = acc_b[c];
                acc_f[c] = 0;
                acc_r[c] = 0;
                acc_b[c] = int'(dir_busy[c]);
            end
            done_cnt++;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_f[c] += int'(PWM_frwrd[c]);
                acc_r[c] += int'(PWM_rev[c]);
                acc_b[c] += int'(dir_busy[c]);
            end
        end
    end

    task automatic waitPeriodEnd();
        int start;
        bit seen;
        start = done_cnt;
        seen  = 1'b0;
        for (int k = 0; k < PERIOD + 200; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt != start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL period_end_timeout: got no period end, expected one within %0d clocks", PERIOD + 200);
        end
    endtask

    task automatic waitCnt(input int value);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < PERIOD + 200; k++) begin
            @(negedge clk);
            if (m_cnt == value) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL cnt_timeout: got no cnt=%0d, expected it within %0d clocks", value, PERIOD + 200);
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(12'h400, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_frwrd", 32'(PWM_frwrd), 32'd0);
        checkOutput("rst_rev", 32'(PWM_rev), 32'd0);
        checkOutput("rst_busy", 32'(dir_busy), 32'd0);
        checkOutput("rst_period_start", 32'(period_start), 32'd1);
        #2 rst_n = 1'b1;

        // First period all low, then 1024-clock pulse rising one clock after period_start
        waitPeriodEnd();
        checkOutput("p0_hi_f0", 32'(pub_f[0]), 32'd0);
        checkOutput("p0_hi_r0", 32'(pub_r[0]), 32'd0);
        checkOutput("p1_start_ps", 32'(period_start), 32'd1);
        checkOutput("p1_start_f0", 32'(PWM_frwrd[0]), 32'd0);
        @(negedge clk);
        checkOutput("p1_rise_f0", 32'(PWM_frwrd[0]), 32'd1);
        applyStimulus(0, 0, 1'b0, 1'b0);
        waitPeriodEnd();
        checkOutput("p1_hi_f0", 32'(pub_f[0]), 32'd1024);
        checkOutput("p1_hi_r0", 32'(pub_r[0]), 32'd0);

        // Duty boundaries
        applyStimulus(12'h7FF, 0, 1'b0, 1'b0);
        waitPeriodEnd();
        checkOutput("spd0_zero_hi", 32'(pub_f[0]), 32'd0);
        applyStimulus(12'h100, 0, 1'b0, 1'b0);
        waitPeriodEnd();
        checkOutput("spd0_max_hi", 32'(pub_f[0]), 32'd2047);

        // Mid-period speed change waits for the next period
        waitPeriodEnd();
        waitCnt(12'h050);
        applyStimulus(12'h600, 0, 1'b0, 1'b0);
        waitPeriodEnd();
        checkOutput("shadow_old_hi", 32'(pub_f[0]), 32'd256);
        waitPeriodEnd();
        checkOutput("shadow_new_hi", 32'(pub_f[0]), 32'd1536);

        // Direction reversal with dead time
        waitCnt(12'h400);
        applyStimulus(12'h200, 0, 1'b1, 1'b0);
        waitPeriodEnd();
        waitPeriodEnd();
        checkOutput("rev_hi_r0", 32'(pub_r[0]), 32'd496);
        checkOutput("rev_hi_f0", 32'(pub_f[0]), 32'd0);
        checkOutput("rev_busy0", 32'(pub_b[0]), 32'd16);

        // Channel 1 reverses, channel 0 steady
        applyStimulus(12'h300, 12'h100, 1'b1, 1'b1);
        waitPeriodEnd();
        waitPeriodEnd();
        checkOutput("indep_hi_r0", 32'(pub_r[0]), 32'd768);
        checkOutput("indep_busy0", 32'(pub_b[0]), 32'd0);
        checkOutput("indep_hi_r1", 32'(pub_r[1]), 32'd240);
        checkOutput("indep_busy1", 32'(pub_b[1]), 32'd16);

        // Asynchronous reset while channel 1 forward output is high
        applyStimulus(12'h300, 12'h100, 1'b1, 1'b0);
        waitPeriodEnd();
        waitCnt(12'h020);
        checkOutput("pre_rst_f1", 32'(PWM_frwrd[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_frwrd", 32'(PWM_frwrd), 32'd0);
        checkOutput("async_rst_rev", 32'(PWM_rev), 32'd0);
        checkOutput("async_rst_busy", 32'(dir_busy), 32'd0);
        applyStimulus(12'h300, 12'h100, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        waitPeriodEnd();
        checkOutput("post_rst_hi_f0", 32'(pub_f[0]), 32'd0);
        checkOutput("post_rst_hi_f1", 32'(pub_f[1]), 32'd0);
        checkOutput("post_rst_hi_r0", 32'(pub_r[0]), 32'd0);

`ifdef MTR_DRV_BRAKE_EN
        // Brake pulse of 10 clocks in the middle of the high phase
        waitCnt(12'h100);
        brake_in[0] = 1'b1;
        repeat (10) @(negedge clk);
        brake_in[0] = 1'b0;
        waitPeriodEnd();
        checkOutput("brake_hi_f0", 32'(pub_f[0]), 32'd758);
`else
        waitPeriodEnd();
        checkOutput("resume_hi_f0", 32'(pub_f[0]), 32'd768);
`endif
        checkOutput("resume_hi_f1", 32'(pub_f[1]), 32'd256);
        checkOutput("resume_busy0", 32'(pub_b[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
